// File: rtl/wb_addr_decoder_if.sv
// Bus bundle for the address decoder: Wishbone master side plus the fan-out
// to four 8-bit slaves. The decoder uses the slave modport, the bridge the master one.
interface wb_addr_decoder_if;
    logic [15:0] wb_adr_i;
    logic [7:0]  wb_dat_i;
    logic [7:0]  wb_dat_o;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;
    logic [7:0]  s_adr_o;
    logic [7:0]  s_dat_o;
    logic        s_we_o;
    logic [3:0]  s_cyc_o;
    logic [3:0]  s_stb_o;
    logic [31:0] s_dat_i;
    logic [3:0]  s_ack_i;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o,
        output s_adr_o, s_dat_o, s_we_o, s_cyc_o, s_stb_o,
        input  s_dat_i, s_ack_i
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o,
        input  s_adr_o, s_dat_o, s_we_o, s_cyc_o, s_stb_o,
        output s_dat_i, s_ack_i
    );
endinterface

// File: rtl/wb_addr_decoder.sv
// Wishbone address decoder: routes the SPI-bridge master to four slaves or to
// internal error-log registers, with a slave-response timeout.
module wb_addr_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_addr_decoder_if.slave bus,
    output logic             err_irq_o
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SLAVE = 2'd1,
        ACK   = 2'd2
    } state_t;

    // The counter starts at zero on SLAVE entry, so the last waiting cycle is N-1.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [7:0] ERR_DATA = 8'hEE;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    state_t      state_r;
    logic [15:0] adr_r;
    logic        we_r;
    logic [1:0]  sel_r;
    logic [7:0]  tmo_cnt_r;
    logic        wb_ack_r;
    logic [7:0]  wb_dat_r;
    logic [3:0]  s_cyc_r;
    logic [3:0]  s_stb_r;
    logic [7:0]  s_adr_r;
    logic [7:0]  s_dat_r;
    logic        s_we_r;
    logic [7:0]  err_count_r;
    logic [15:0] err_addr_r;
    logic        timeout_seen_r;
    logic        unmapped_seen_r;
    logic        err_irq_r;

    logic        req_s;
    logic        hit_slave_s;
    logic        hit_int_s;
    logic        clear_s;
    logic        ack_sel_s;
    logic [7:0]  int_rdata_s;
    logic [7:0]  slave_rdata_s;

    // Address decode, internal register read mux and selected-slave return path
    always_comb begin
        req_s       = bus.wb_cyc_i & bus.wb_stb_i;
        hit_slave_s = (bus.wb_adr_i[15:10] == 6'd0);
        hit_int_s   = (bus.wb_adr_i[15:8] == 8'hFF);
        clear_s     = hit_int_s & bus.wb_we_i & (bus.wb_adr_i[7:0] == 8'h03);
        case (bus.wb_adr_i[7:0])
            8'h00:   int_rdata_s = err_count_r;
            8'h01:   int_rdata_s = err_addr_r[15:8];
            8'h02:   int_rdata_s = err_addr_r[7:0];
            8'h03:   int_rdata_s = {6'b000000, unmapped_seen_r, timeout_seen_r};
            default: int_rdata_s = 8'h00;
        endcase
        case (sel_r)
            2'd0:    slave_rdata_s = bus.s_dat_i[7:0];
            2'd1:    slave_rdata_s = bus.s_dat_i[15:8];
            2'd2:    slave_rdata_s = bus.s_dat_i[23:16];
            2'd3:    slave_rdata_s = bus.s_dat_i[31:24];
            default: slave_rdata_s = bus.s_dat_i[7:0];
        endcase
        ack_sel_s = bus.s_ack_i[sel_r];
    end

    // Transaction FSM with all bus outputs and error-log state registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            adr_r           <= 16'h0000;
            we_r            <= 1'b0;
            sel_r           <= 2'd0;
            tmo_cnt_r       <= 8'd0;
            wb_ack_r        <= 1'b0;
            wb_dat_r        <= 8'h00;
            s_cyc_r         <= 4'b0000;
            s_stb_r         <= 4'b0000;
            s_adr_r         <= 8'h00;
            s_dat_r         <= 8'h00;
            s_we_r          <= 1'b0;
            err_count_r     <= 8'h00;
            err_addr_r      <= 16'h0000;
            timeout_seen_r  <= 1'b0;
            unmapped_seen_r <= 1'b0;
            err_irq_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    wb_ack_r <= 1'b0;
                    if (req_s) begin
                        adr_r <= bus.wb_adr_i;
                        we_r  <= bus.wb_we_i;
                        sel_r <= bus.wb_adr_i[9:8];
                        if (hit_slave_s) begin
                            state_r   <= SLAVE;
                            tmo_cnt_r <= 8'd0;
                            s_cyc_r   <= onehot4(bus.wb_adr_i[9:8]);
                            s_stb_r   <= onehot4(bus.wb_adr_i[9:8]);
                            s_adr_r   <= bus.wb_adr_i[7:0];
                            s_dat_r   <= bus.wb_dat_i;
                            s_we_r    <= bus.wb_we_i;
                        end else if (hit_int_s) begin
                            state_r  <= ACK;
                            wb_ack_r <= 1'b1;
                            if (clear_s) begin
                                err_count_r     <= 8'h00;
                                err_addr_r      <= 16'h0000;
                                timeout_seen_r  <= 1'b0;
                                unmapped_seen_r <= 1'b0;
                                err_irq_r       <= 1'b0;
                            end else if (!bus.wb_we_i) begin
                                wb_dat_r <= int_rdata_s;
                            end else begin
                                wb_dat_r <= wb_dat_r;
                            end
                        end else begin
                            state_r         <= ACK;
                            wb_ack_r        <= 1'b1;
                            unmapped_seen_r <= 1'b1;
                            err_irq_r       <= 1'b1;
                            err_addr_r      <= bus.wb_adr_i;
                            err_count_r     <= sat_inc8(err_count_r);
                            if (!bus.wb_we_i) begin
                                wb_dat_r <= ERR_DATA;
                            end else begin
                                wb_dat_r <= wb_dat_r;
                            end
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SLAVE: begin
                    // Master abort outranks everything, then a slave ack beats the timeout
                    if (!bus.wb_cyc_i) begin
                        state_r <= IDLE;
                        s_cyc_r <= 4'b0000;
                        s_stb_r <= 4'b0000;
                    end else if (ack_sel_s) begin
                        state_r  <= ACK;
                        wb_ack_r <= 1'b1;
                        s_cyc_r  <= 4'b0000;
                        s_stb_r  <= 4'b0000;
                        if (!we_r) begin
                            wb_dat_r <= slave_rdata_s;
                        end else begin
                            wb_dat_r <= wb_dat_r;
                        end
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        state_r        <= ACK;
                        wb_ack_r       <= 1'b1;
                        s_cyc_r        <= 4'b0000;
                        s_stb_r        <= 4'b0000;
                        timeout_seen_r <= 1'b1;
                        err_irq_r      <= 1'b1;
                        err_addr_r     <= adr_r;
                        err_count_r    <= sat_inc8(err_count_r);
                        if (!we_r) begin
                            wb_dat_r <= ERR_DATA;
                        end else begin
                            wb_dat_r <= wb_dat_r;
                        end
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 8'd1;
                    end
                end
                ACK: begin
                    state_r  <= IDLE;
                    wb_ack_r <= 1'b0;
                end
                default: begin
                    state_r  <= IDLE;
                    wb_ack_r <= 1'b0;
                    s_cyc_r  <= 4'b0000;
                    s_stb_r  <= 4'b0000;
                end
            endcase
        end
    end

    assign bus.wb_ack_o = wb_ack_r;
    assign bus.wb_dat_o = wb_dat_r;
    assign bus.s_cyc_o  = s_cyc_r;
    assign bus.s_stb_o  = s_stb_r;
    assign bus.s_adr_o  = s_adr_r;
    assign bus.s_dat_o  = s_dat_r;
    assign bus.s_we_o   = s_we_r;
    assign err_irq_o    = err_irq_r;

endmodule

// File: doc/wb_addr_decoder.md
WB_ADDR_DECODER -- requirements
Module: wb_addr_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, SHALL set slave-response timeout in clk cycles, legal range 1..255.
REQ-002 Port clk, input, 1: single clock; all logic SHALL be on its rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 Master side from SPI bridge SHALL be: wb_adr_i in 16; wb_dat_i in 8; wb_dat_o out 8; wb_we_i in 1; wb_cyc_i in 1; wb_stb_i in 1; wb_ack_o out 1.
REQ-005 Slave side SHALL be: s_adr_o out 8; s_dat_o out 8; s_we_o out 1; s_cyc_o out 4; s_stb_o out 4; s_dat_i in 32 (slave n on bits [8n+7:8n]); s_ack_i in 4.
REQ-006 Port err_irq_o, output, 1: high while any status bit is set.

Function
REQ-007 Address map SHALL be: wb_adr_i[15:8] 0x00..0x03 selects slave 0..3; 0xFF selects internal registers; all others unmapped.
REQ-008 Internal registers SHALL be: 0xFF00 err_count (RO); 0xFF01 err_addr[15:8] (RO); 0xFF02 err_addr[7:0] (RO); 0xFF03 status {6'b0, unmapped_seen, timeout_seen}; other 0xFFxx reads return 0x00.
REQ-009 Any write to 0xFF03 SHALL clear status, err_count and err_addr; writes to other internal addresses SHALL be acked and ignored.
REQ-010 FSM states SHALL be IDLE, SLAVE, ACK.
REQ-011 IDLE: on wb_cyc_i & wb_stb_i, latch address, data and we; slave hit -> SLAVE; internal or unmapped -> ACK.
REQ-012 In SLAVE, s_cyc_o[n] and s_stb_o[n] SHALL be registered high for the selected slave only, with s_adr_o = latched adr[7:0], s_dat_o and s_we_o = latched values; all other slave strobes SHALL be low.
REQ-013 In SLAVE, s_ack_i[n] high SHALL capture s_dat_i[n] into wb_dat_o (read) and go to ACK; s_ack_i bits of unselected slaves SHALL be ignored.
REQ-014 Timeout counter SHALL clear on SLAVE entry and increment each SLAVE cycle; when it reaches TIMEOUT_CYCLES without ack, go to ACK with wb_dat_o = 0xEE, set timeout_seen, record err_addr, increment err_count.
REQ-015 s_ack_i and timeout in the same cycle: ack SHALL win and no error SHALL be recorded.
REQ-016 Unmapped access SHALL go to ACK with wb_dat_o = 0xEE, set unmapped_seen, record err_addr, increment err_count.
REQ-017 err_count SHALL saturate at 0xFF; err_addr SHALL hold the most recent error address.
REQ-018 ACK: wb_ack_o SHALL be high for exactly one cycle with read data valid; all s_stb_o/s_cyc_o low; next state IDLE.
REQ-019 Latency from stb sample: internal/unmapped ack 1 cycle; slave ack 1 cycle after s_ack_i sampled; minimum slave round trip 2 cycles.
REQ-020 wb_cyc_i low while in SLAVE SHALL abort: slave strobes drop next cycle, go to IDLE, no ack, no error recorded.
REQ-021 wb_dat_o SHALL hold its last value outside ACK; write accesses SHALL leave wb_dat_o unchanged.
REQ-022 A new master request SHALL only be accepted in IDLE; requests are never queued.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, wb_ack_o 0, wb_dat_o 0x00, s_cyc_o/s_stb_o 0, s_adr_o/s_dat_o/s_we_o 0, err_count 0, err_addr 0, status 0, err_irq_o 0.
REQ-024 Reset asserted mid-transaction SHALL abort it with no ack issued after release.

Verification
REQ-025 Read 0x0001, slave 0 acks with 0x5A after 3 cycles -> only s_stb_o[0] high, s_adr_o 0x01, wb_ack_o one cycle, wb_dat_o 0x5A.
REQ-026 Write 0x0203 data 0x77, slave 2 never acks, TIMEOUT_CYCLES 64 -> ack after 64 SLAVE cycles, 0xFF03 reads 0x01, 0xFF00 reads 0x01, 0xFF01/02 read 0x02/0x03, err_irq_o 1.
REQ-027 Read 0x1234 -> ack 1 cycle later, data 0xEE, status 0x02; then write 0xFF03 -> status 0x00, err_count 0x00, err_irq_o 0.
REQ-028 Slave 1 acks on exactly the timeout cycle with 0x3C -> data 0x3C, status unchanged.
REQ-029 300 unmapped reads -> err_count 0xFF; master drops cyc mid-SLAVE -> no ack, strobes low next cycle.
REQ-030 rst_n pulsed low during SLAVE -> all outputs at reset values asynchronously, no ack after release.
